msx_mouse_reader: RTL and testbench
===================================

# msx_mouse_reader

Host-side initiator for the MSX strobe-multiplexed mouse protocol on a DB9 port. It drives the port strobe (pin 8) through four toggles per frame, samples one 4-bit nibble per phase and assembles signed X/Y displacement bytes plus button state. It also tracks whether a mouse or a plain joystick is attached. It sits between the DB9 input pins and the joystick/mouse mux in `emu`, running on clk_sys alongside the PS/2-to-MSX mouse responder.

## Interface
Parameters:
- POLL_CYC, 357955: cycles between frame starts (60 Hz at 21.477 MHz); must exceed 4*(SETTLE_CYC+1)+2.
- SETTLE_CYC, 2148: cycles from a strobe edge to the nibble sample (~100 µs).
- MISS_MAX, 4: consecutive all-F frames that clear `present`.

Ports:
- clk_sys  in  1  system clock. One clock domain only.
- reset  in  1  reset, asynchronous, active-high.
- enable  in  1  polling enable; 0 forces IDLE.
- data_in  in  6  raw DB9 levels: [3:0] nibble D3..D0, [4] button1 (pin 6), [5] button2 (pin 7), active-low.
- strobe  out  1  strobe drive to DB9 pin 8.
- dx  out  8  X displacement, two's complement, MSX convention (positive = left).
- dy  out  8  Y displacement, two's complement, MSX convention (positive = up).
- buttons  out  2  [0]=button1, [1]=button2, active-high.
- valid  out  1  one-cycle pulse when dx/dy/buttons update.
- present  out  1  1 = mouse detected on port.

## Operation
- data_in passes through a 2-FF synchronizer. All samples use the synchronizer output `ds`.
- Poll counter: free-running, counts POLL_CYC-1 down to 0, then reloads and emits `tick`. It runs regardless of state.
- FSM states: IDLE, PH0, PH1, PH2, PH3, DONE.
  - IDLE: strobe=0. On tick with enable=1, go to PH0 and set strobe=1.
  - PH0: wait SETTLE_CYC, then xh<=ds[3:0], strobe<=0, go to PH1.
  - PH1: wait SETTLE_CYC, then xl<=ds[3:0], strobe<=1, go to PH2.
  - PH2: wait SETTLE_CYC, then yh<=ds[3:0], strobe<=0, go to PH3.
  - PH3: wait SETTLE_CYC, then yl<=ds[3:0] and btn<=~ds[5:4], go to DONE.
  - DONE: one cycle. dx<={xh,xl}, dy<={yh,yl}, buttons<=btn, valid<=1, presence update, then IDLE.
- Settle counter reloads to SETTLE_CYC-1 on every strobe edge and on entry to PH0.
- A tick arriving while not in IDLE is dropped; there is no queueing.
- Presence: an all-F frame has xh=xl=yh=yl=4'hF.
  - Not all-F: present<=1 and miss counter<=0.
  - All-F: miss counter increments, saturating at MISS_MAX. present<=0 when it reaches MISS_MAX.
  - dx/dy/buttons/valid update on every frame regardless of present.
- enable=0 in any state: next cycle the FSM is IDLE, strobe=0, no valid. Partial nibbles are discarded, outputs are held, and the miss counter and present are unchanged.
- dx/dy are passed raw: no accumulation, no saturation.

## Timing
- Reset values: strobe=0, dx=0, dy=0, buttons=0, valid=0, present=0, FSM=IDLE, miss=0, poll counter=POLL_CYC-1.
- Strobe rises on the cycle after tick. Each sample is taken SETTLE_CYC cycles after its strobe edge, and the next edge happens in the same cycle as the sample.
- valid asserts 4*SETTLE_CYC+1 cycles after the strobe first rises. Outputs change in that same cycle.
- Pin-to-sample latency is 2 cycles (synchronizer); data must be stable from SETTLE_CYC-2 cycles after the edge.
- Strobe ends each frame low and stays low ≥ POLL_CYC-4*SETTLE_CYC-2 cycles, which exceeds the 1.5 ms mouse resync gap.
- Asynchronous reset mid-frame: outputs go to reset values immediately. The frame restarts only on the next tick after release.

## Test plan
Common setup: SETTLE_CYC=8, POLL_CYC=100, MISS_MAX=4.

1. **Mouse model, basic frame.** Model presents nibbles 3,C,F,E per strobe phase with buttons pins=2'b10 -> valid once per 100 cycles, dx=8'h3C, dy=8'hFE, buttons=2'b01, present=1; strobe shows exactly 4 edges per frame.
2. **Latency.** Measure from the first strobe rise to valid -> 33 cycles; strobe is low and FSM is IDLE on the following cycle.
3. **Joystick at rest.** data_in=6'h3F constant -> dx=dy=8'hFF each frame; present drops on the 4th all-F frame after a mouse frame, not the 3rd.
4. **enable drop.** Deassert enable during PH2 -> strobe=0 next cycle, no valid, dx/dy keep their prior values; re-enable gives a full frame on the next tick.
5. **Async reset in PH1.** Assert reset mid-PH1 -> all outputs 0 at once with no clock edge needed; after release, the first strobe rise follows the first tick at 100 cycles.
6. **Sample point.** Change the nibble 5 cycles after a strobe edge -> new value captured; change it 7 cycles after -> old value captured.

Source files
------------

// File: rtl/msx_mouse_reader.sv
// msx_mouse_reader: host-side poller for an MSX strobe-multiplexed mouse.
// Toggles the DB9 strobe four times per frame and samples one nibble per phase.
// Assembles raw X/Y displacement bytes and button state.
// Tracks mouse presence by counting consecutive all-F (idle joystick) frames.
module msx_mouse_reader #(
  parameter int POLL_CYC   = 357955,
  parameter int SETTLE_CYC = 2148,
  parameter int MISS_MAX   = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              enable,
  input  logic [5:0]        data_in,
  output logic              strobe,
  output logic signed [7:0] dx,
  output logic signed [7:0] dy,
  output logic [1:0]        buttons,
  output logic              valid,
  output logic              present
);

  localparam int PW = $clog2(POLL_CYC + 1);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int MW = $clog2(MISS_MAX + 1);
  localparam logic [PW-1:0] POLL_LOAD   = PW'(POLL_CYC - 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYC - 1);
  localparam logic [MW-1:0] MISS_SAT    = MW'(MISS_MAX);

  typedef enum logic [2:0] {IDLE, PH0, PH1, PH2, PH3, DONE} state_t;

  state_t        state;
  state_t        state_nx;
  logic [5:0]    sync_p0;
  logic [5:0]    ds;
  logic [PW-1:0] poll_cnt;
  logic          tick;
  logic [SW-1:0] settle_cnt;
  logic          settle_done;
  logic          settle_ld;
  logic          strobe_nx;
  logic [3:0]    cap;
  logic          done;
  logic [3:0]    xh;
  logic [3:0]    xl;
  logic [3:0]    yh;
  logic [3:0]    yl;
  logic [1:0]    btn;
  logic [MW-1:0] miss;
  logic [MW-1:0] miss_nx;
  logic          all_f;

  // Miss counter increment that sticks at the absence threshold
  function automatic logic [MW-1:0] sat_inc(input logic [MW-1:0] v);
    return (v == MISS_SAT) ? v : v + MW'(1);
  endfunction

  assign tick        = (poll_cnt == '0);
  assign settle_done = (settle_cnt == '0);
  assign all_f       = (xh == 4'hF) && (xl == 4'hF) && (yh == 4'hF) && (yl == 4'hF);
  assign miss_nx     = sat_inc(miss);

  // Two-flop synchronizer on the raw pin levels (data path, no reset)
  always_ff @(posedge clk_sys) begin
    sync_p0 <= data_in;
    ds      <= sync_p0;
  end

  // Free-running frame timer, independent of the FSM
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) poll_cnt <= POLL_LOAD;
    else       poll_cnt <= tick ? POLL_LOAD : poll_cnt - 1'b1;
  end

  // Settle timer restarted on every strobe edge, counts down to the sample point
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)                 settle_cnt <= '0;
    else if (settle_ld)        settle_cnt <= SETTLE_LOAD;
    else if (!settle_done)     settle_cnt <= settle_cnt - 1'b1;
  end

  // FSM state and strobe registers
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      strobe <= 1'b0;
    end else begin
      state  <= state_nx;
      strobe <= strobe_nx;
    end
  end

  // Next-state, strobe drive and capture strobes; enable low aborts to IDLE
  always_comb begin
    state_nx  = state;
    strobe_nx = strobe;
    settle_ld = 1'b0;
    cap       = 4'b0000;
    done      = 1'b0;
    if (!enable) begin
      state_nx  = IDLE;
      strobe_nx = 1'b0;
    end else begin
      case (state)
        IDLE: if (tick) begin
          state_nx  = PH0;
          strobe_nx = 1'b1;
          settle_ld = 1'b1;
        end
        PH0: if (settle_done) begin
          cap[0]    = 1'b1;
          strobe_nx = 1'b0;
          settle_ld = 1'b1;
          state_nx  = PH1;
        end
        PH1: if (settle_done) begin
          cap[1]    = 1'b1;
          strobe_nx = 1'b1;
          settle_ld = 1'b1;
          state_nx  = PH2;
        end
        PH2: if (settle_done) begin
          cap[2]    = 1'b1;
          strobe_nx = 1'b0;
          settle_ld = 1'b1;
          state_nx  = PH3;
        end
        PH3: if (settle_done) begin
          cap[3]    = 1'b1;
          state_nx  = DONE;
        end
        DONE: begin
          done      = 1'b1;
          state_nx  = IDLE;
        end
        default: begin
          state_nx  = IDLE;
          strobe_nx = 1'b0;
        end
      endcase
    end
  end

  // Nibble capture registers (data path, no reset)
  always_ff @(posedge clk_sys) begin
    if (cap[0]) xh <= ds[3:0];
    if (cap[1]) xl <= ds[3:0];
    if (cap[2]) yh <= ds[3:0];
    if (cap[3]) begin
      yl  <= ds[3:0];
      btn <= ~ds[5:4];
    end
  end

  // Frame publication and presence tracking
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dx      <= '0;
      dy      <= '0;
      buttons <= '0;
      valid   <= 1'b0;
      present <= 1'b0;
      miss    <= '0;
    end else begin
      valid <= 1'b0;
      if (done) begin
        dx      <= {xh, xl};
        dy      <= {yh, yl};
        buttons <= btn;
        valid   <= 1'b1;
        if (all_f) begin
          miss <= miss_nx;
          if (miss_nx == MISS_SAT) present <= 1'b0;
        end else begin
          miss    <= '0;
          present <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_msx_mouse_reader.sv
// Testbench for msx_mouse_reader: mouse model plus frame scoreboard.
`timescale 1ns/1ps
module tb_msx_mouse_reader;

  localparam int POLL   = 100;
  localparam int SETTLE = 8;
  localparam int MISS   = 4;

  logic              clk_sys = 1'b0;
  logic              reset   = 1'b0;
  logic              enable  = 1'b0;
  wire  [5:0]        data_in;
  logic              strobe;
  logic signed [7:0] dx;
  logic signed [7:0] dy;
  logic [1:0]        buttons;
  logic              valid;
  logic              present;

  msx_mouse_reader #(
    .POLL_CYC  (POLL),
    .SETTLE_CYC(SETTLE),
    .MISS_MAX  (MISS)
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .enable (enable),
    .data_in(data_in),
    .strobe (strobe),
    .dx     (dx),
    .dy     (dy),
    .buttons(buttons),
    .valid  (valid),
    .present(present)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [7:0] dx;
    logic [7:0] dy;
    logic [1:0] btn;
    logic       pres;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  // Mouse model: nibble index follows strobe edges, resyncs after a quiet gap
  bit         model_on = 1'b0;
  logic [3:0] m_nib [4];
  logic [1:0] m_btn    = 2'b11;
  logic [3:0] m_cur    = 4'hF;
  logic [5:0] man_data = 6'h3F;
  int         m_idx    = 0;
  int         quiet    = 1000;
  logic       strobe_q = 1'b0;

  assign data_in = model_on ? {m_btn, m_cur} : man_data;

  always @(negedge clk_sys) begin
    if (strobe !== strobe_q) begin
      if (quiet > 20) m_idx = 0;
      else if (m_idx < 3) m_idx = m_idx + 1;
      quiet = 0;
    end else if (quiet < 1000) begin
      quiet = quiet + 1;
    end
    strobe_q = strobe;
    m_cur    = m_nib[m_idx];
  end

  // Scoreboard: every valid pulse pops one expected frame
  always @(negedge clk_sys) begin
    if (valid === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL frame_unexpected: got dx=%h dy=%h btn=%b present=%b, required no valid",
                 dx, dy, buttons, present);
      end else begin
        mon_e = exp_q.pop_front();
        if ({dx, dy, buttons, present} !== mon_e) begin
          n_err++;
          $display("FAIL frame: got dx=%h dy=%h btn=%b present=%b, required dx=%h dy=%h btn=%b present=%b",
                   dx, dy, buttons, present, mon_e.dx, mon_e.dy, mon_e.btn, mon_e.pres);
        end
      end
    end
  end

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_sys);
      if (valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rise(input int budget, output bit ok, output int cyc);
    logic p;
    p   = strobe;
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_sys);
      cyc++;
      if (strobe === 1'b1 && p === 1'b0) begin
        ok = 1'b1;
        break;
      end
      p = strobe;
    end
  endtask

  task automatic set_model(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d,
                           input logic [1:0] pins);
    m_nib[0] = a;
    m_nib[1] = b;
    m_nib[2] = c;
    m_nib[3] = d;
    m_btn    = pins;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    n_vec++;
    if ({strobe, dx, dy, buttons, valid, present} !== 20'h0) begin
      n_err++;
      $display("FAIL reset_values: got strobe=%b dx=%h dy=%h btn=%b valid=%b present=%b, required all 0",
               strobe, dx, dy, buttons, valid, present);
    end
  endtask

  task automatic test_basic_frame();
    bit   ok;
    bit   got;
    int   edges;
    int   cyc;
    logic p;
    set_model(4'h3, 4'hC, 4'hF, 4'hE, 2'b10);
    model_on = 1'b1;
    enable   = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back('{8'h3C, 8'hFE, 2'b01, 1'b1});
    @(negedge clk_sys);
    reset = 1'b0;
    wait_valid(300, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL basic_first_valid: got timeout, required valid within 300 cycles");
    end
    for (int f = 0; f < 2; f++) begin
      edges = 0;
      cyc   = 0;
      got   = 1'b0;
      p     = strobe;
      for (int i = 0; i < 300 && !got; i++) begin
        @(negedge clk_sys);
        cyc++;
        if (strobe !== p) edges++;
        p = strobe;
        if (valid === 1'b1) got = 1'b1;
      end
      n_vec++;
      if (!got || cyc != POLL) begin
        n_err++;
        $display("FAIL basic_period: got %0d cycles (seen=%b), required %0d", cyc, got, POLL);
      end
      n_vec++;
      if (edges != 4) begin
        n_err++;
        $display("FAIL basic_strobe_edges: got %0d, required 4", edges);
      end
    end
  endtask

  task automatic test_latency();
    bit ok;
    int c;
    int n;
    bit high_seen;
    exp_q.push_back('{8'h3C, 8'hFE, 2'b01, 1'b1});
    wait_rise(200, ok, c);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_sys);
      n++;
      if (valid === 1'b1) break;
    end
    n_vec++;
    if (!ok || n != 4 * SETTLE + 1) begin
      n_err++;
      $display("FAIL latency: got %0d cycles (rise seen=%b), required %0d", n, ok, 4 * SETTLE + 1);
    end
    @(negedge clk_sys);
    n_vec++;
    if (strobe !== 1'b0 || valid !== 1'b0) begin
      n_err++;
      $display("FAIL latency_after: got strobe=%b valid=%b, required 0 0", strobe, valid);
    end
    high_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_sys);
      if (strobe !== 1'b0) high_seen = 1'b1;
    end
    n_vec++;
    if (high_seen) begin
      n_err++;
      $display("FAIL idle_gap: got strobe high inside gap, required low");
    end
  endtask

  task automatic test_joystick();
    bit ok;
    model_on = 1'b0;
    man_data = 6'h3F;
    for (int i = 0; i < 5; i++)
      exp_q.push_back('{8'hFF, 8'hFF, 2'b00, (i < 3) ? 1'b1 : 1'b0});
    for (int i = 0; i < 5; i++) begin
      wait_valid(150, ok);
      n_vec++;
      if (!ok) begin
        n_err++;
        $display("FAIL joy_valid_%0d: got timeout, required valid", i);
      end
      if (i == 2) begin
        n_vec++;
        if (present !== 1'b1) begin
          n_err++;
          $display("FAIL joy_present_3rd: got %b, required 1", present);
        end
      end
      if (i == 3) begin
        n_vec++;
        if (present !== 1'b0) begin
          n_err++;
          $display("FAIL joy_present_4th: got %b, required 0", present);
        end
      end
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int c;
    bit bad;
    set_model(4'h1, 4'h2, 4'h3, 4'h4, 2'b01);
    model_on = 1'b1;
    exp_q.push_back('{8'h12, 8'h34, 2'b10, 1'b1});
    wait_valid(150, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL en_first_valid: got timeout, required valid");
    end
    wait_rise(150, ok, c);
    repeat (2 * SETTLE + 2) @(negedge clk_sys);
    enable = 1'b0;
    @(negedge clk_sys);
    n_vec++;
    if (strobe !== 1'b0) begin
      n_err++;
      $display("FAIL en_strobe_drop: got %b, required 0", strobe);
    end
    bad = 1'b0;
    set_model(4'h5, 4'h6, 4'h7, 4'h8, 2'b11);
    for (int i = 0; i < 150; i++) begin
      @(negedge clk_sys);
      if (strobe !== 1'b0 || valid !== 1'b0) bad = 1'b1;
    end
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL en_disabled_quiet: got strobe/valid activity, required none");
    end
    n_vec++;
    if (dx !== 8'h12 || dy !== 8'h34) begin
      n_err++;
      $display("FAIL en_hold: got dx=%h dy=%h, required dx=12 dy=34", dx, dy);
    end
    enable = 1'b1;
    exp_q.push_back('{8'h56, 8'h78, 2'b00, 1'b1});
    wait_valid(250, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL en_resume: got timeout, required valid");
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    int c;
    wait_rise(150, ok, c);
    repeat (SETTLE + 2) @(negedge clk_sys);
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if ({strobe, dx, dy, buttons, valid, present} !== 20'h0) begin
      n_err++;
      $display("FAIL async_reset: got strobe=%b dx=%h dy=%h btn=%b valid=%b present=%b, required all 0",
               strobe, dx, dy, buttons, valid, present);
    end
    @(negedge clk_sys);
    @(negedge clk_sys);
    reset = 1'b0;
    exp_q.push_back('{8'h56, 8'h78, 2'b00, 1'b1});
    wait_rise(300, ok, c);
    n_vec++;
    if (!ok || c != POLL) begin
      n_err++;
      $display("FAIL reset_restart: got first rise after %0d cycles (seen=%b), required %0d", c, ok, POLL);
    end
    wait_valid(60, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL reset_frame: got timeout, required valid");
    end
  endtask

  task automatic test_sample_point();
    bit ok;
    int c;
    model_on = 1'b0;
    man_data = 6'b11_0000;
    exp_q.push_back('{8'hAA, 8'h39, 2'b00, 1'b1});
    wait_rise(150, ok, c);
    repeat (5)  @(negedge clk_sys);
    man_data[3:0] = 4'hA;
    repeat (10) @(negedge clk_sys);
    man_data[3:0] = 4'h5;
    repeat (6)  @(negedge clk_sys);
    man_data[3:0] = 4'h3;
    repeat (8)  @(negedge clk_sys);
    man_data[3:0] = 4'h9;
    repeat (2)  @(negedge clk_sys);
    man_data[3:0] = 4'h0;
    wait_valid(20, ok);
    n_vec++;
    if (!ok || dx !== 8'hAA || dy !== 8'h39) begin
      n_err++;
      $display("FAIL sample_point: got dx=%h dy=%h (seen=%b), required dx=aa dy=39", dx, dy, ok);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_latency();
    test_joystick();
    test_enable_drop();
    test_async_reset();
    test_sample_point();
    repeat (5) @(negedge clk_sys);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending frames, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
